ifu_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the single-cycle RV64 core datapath.
- Fetches 8-byte-aligned doublewords from instruction memory over a req/gnt/rvalid handshake and holds the last one in a one-line buffer.
- Delivers one 32-bit instruction per cycle to decode over a valid/ready handshake, selecting the half with pc[2].
- Handles branch/jump redirects, halt (ebreak) and line invalidation (fence.i).

---
 rtl/ifu_fetch.sv | 119 +++++++++++
 tb/tb_ifu_fetch.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: one-line doubleword buffer filled over req/gnt/rvalid,
// delivering one 32-bit instruction per cycle to decode with redirect/halt/fence.i support.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          XLEN     = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  input  logic            inval,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:3] req_tag_q, req_tag_d;
  logic [XLEN-1:3] line_tag_q, line_tag_d;
  logic [XLEN-1:0] line_data_q, line_data_d;
  logic            line_valid_q, line_valid_d;
  logic            discard_q, discard_d;

  logic hit;
  logic out_fire;

  assign hit       = line_valid_q && (line_tag_q == fetch_pc_q[XLEN-1:3]);
  assign out_valid = (state_q == IDLE) && hit && !halt && !redirect_valid && !rst;
  assign out_fire  = out_valid && out_ready;
  assign out_pc    = fetch_pc_q;
  assign out_inst  = fetch_pc_q[2] ? line_data_q[63:32] : line_data_q[31:0];

  // The address is captured on REQ entry so pc redirects cannot disturb a pending request.
  assign mem_req  = (state_q == REQ) && !rst;
  assign mem_addr = mem_req ? {req_tag_q, 3'b000} : '0;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_tag_d    = req_tag_q;
    line_tag_d   = line_tag_q;
    line_data_d  = line_data_q;
    line_valid_d = line_valid_q;
    discard_d    = discard_q;

    // fence.i clears first so that a coincident fill below can still set the line valid.
    if (inval) line_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!hit && !halt && !redirect_valid) begin
          state_d   = REQ;
          req_tag_d = fetch_pc_q[XLEN-1:3];
        end
      end
      REQ: begin
        if (redirect_valid) discard_d = 1'b1;
        if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          // A redirect landing on the response cycle makes that response stale too.
          if (!discard_q && !redirect_valid) begin
            line_data_d  = mem_rdata;
            line_tag_d   = req_tag_q;
            line_valid_d = 1'b1;
          end
          discard_d = 1'b0;
          state_d   = IDLE;
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
    end else if (out_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      line_valid_q <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      line_valid_q <= line_valid_d;
      discard_q    <= discard_d;
    end
  end

  // NOTE: data/tag storage is not reset; it is only observed when qualified by line_valid_q or REQ.
  always_ff @(posedge clk) begin
    req_tag_q   <= req_tag_d;
    line_tag_q  <= line_tag_d;
    line_data_q <= line_data_d;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: reset, hit/stall, redirects in WAIT/REQ/IDLE,
// withheld grant, halt and fence.i refetch.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        inval;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inval          (inval),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; inval = 1'b0;
    out_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset held for two edges
    tick(); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mem_req",   64'(mem_req),   64'd0);
    chk("rst_mem_addr",  mem_addr,       64'd0);
    tick(); rst = 1'b0; #1;
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_mem_req",   64'(mem_req),   64'd0);
    chk("post_rst_mem_addr",  mem_addr,       64'd0);

    // First miss: immediate grant, response one cycle later
    tick(); #1;
    chk("miss0_req",  64'(mem_req), 64'd1);
    chk("miss0_addr", mem_addr,     64'h8000_0000);
    mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0010_0073_0000_0013; #1;
    chk("wait0_req",   64'(mem_req),   64'd0);
    chk("wait0_valid", 64'(out_valid), 64'd0);
    tick(); mem_rvalid = 1'b0; out_ready = 1'b1; #1;
    chk("hit0_valid", 64'(out_valid), 64'd1);
    chk("hit0_pc",    out_pc,         64'h8000_0000);
    chk("hit0_inst",  64'(out_inst),  64'h0000_0013);
    chk("hit0_req",   64'(mem_req),   64'd0);

    // Upper half of the same line, stalled by decode for three cycles
    tick(); out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_pc",    out_pc,         64'h8000_0004);
      chk("stall_inst",  64'(out_inst),  64'h0010_0073);
      chk("stall_req",   64'(mem_req),   64'd0);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("hit1_valid", 64'(out_valid), 64'd1);
    chk("hit1_pc",    out_pc,         64'h8000_0004);

    // pc now 0x80000008 (miss); redirect back into the buffered line
    tick(); out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0000; #1;
    chk("redir_idle_valid", 64'(out_valid), 64'd0);
    chk("redir_idle_req",   64'(mem_req),   64'd0);
    tick(); redirect_valid = 1'b0; #1;
    chk("redir_hit_valid", 64'(out_valid), 64'd1);
    chk("redir_hit_pc",    out_pc,         64'h8000_0000);
    chk("redir_hit_inst",  64'(out_inst),  64'h0000_0013);
    chk("redir_hit_req",   64'(mem_req),   64'd0);

    // Miss at 0x80000200, redirect to 0x80000106 while waiting for data
    tick(); redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; #1;
    tick(); redirect_valid = 1'b0; #1;
    chk("miss200_idle_req", 64'(mem_req), 64'd0);
    tick(); #1;
    chk("miss200_req",  64'(mem_req), 64'd1);
    chk("miss200_addr", mem_addr,     64'h8000_0200);
    mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0106; #1;
    chk("wait_redir_req", 64'(mem_req), 64'd0);
    tick(); redirect_valid = 1'b0; #1;
    chk("wait_redir_valid", 64'(out_valid), 64'd0);
    tick(); mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_CAFE_F00D; #1;
    tick(); mem_rvalid = 1'b0; #1;
    chk("after_discard_valid", 64'(out_valid), 64'd0);
    chk("after_discard_req",   64'(mem_req),   64'd0);
    tick(); #1;
    chk("miss100_req",  64'(mem_req), 64'd1);
    chk("miss100_addr", mem_addr,     64'h8000_0100);
    mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1111_1111_2222_2222; #1;
    tick(); mem_rvalid = 1'b0; out_ready = 1'b1; #1;
    chk("hit104_valid", 64'(out_valid), 64'd1);
    chk("hit104_pc",    out_pc,         64'h8000_0104);
    chk("hit104_inst",  64'(out_inst),  64'h1111_1111);

    // Line crossing to 0x80000108, grant withheld 4 cycles, redirect in the 2nd
    tick(); out_ready = 1'b0; #1;
    chk("cross_valid", 64'(out_valid), 64'd0);
    redirect_pc = 64'h8000_0100;
    for (int i = 0; i < 4; i++) begin
      tick(); redirect_valid = (i == 1); #1;
      chk("nogrant_req",  64'(mem_req), 64'd1);
      chk("nogrant_addr", mem_addr,     64'h8000_0108);
    end
    tick(); redirect_valid = 1'b0; mem_gnt = 1'b1; #1;
    chk("grant_req",  64'(mem_req), 64'd1);
    chk("grant_addr", mem_addr,     64'h8000_0108);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h3333_3333_4444_4444; #1;
    chk("wait108_req", 64'(mem_req), 64'd0);
    tick(); mem_rvalid = 1'b0; #1;
    chk("kept_line_valid", 64'(out_valid), 64'd1);
    chk("kept_line_pc",    out_pc,         64'h8000_0100);
    chk("kept_line_inst",  64'(out_inst),  64'h2222_2222);

    // Halt on a miss: nothing issued, nothing delivered
    tick(); redirect_valid = 1'b1; redirect_pc = 64'h8000_0400; halt = 1'b1; #1;
    tick(); redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halt_req",   64'(mem_req),   64'd0);
      chk("halt_valid", 64'(out_valid), 64'd0);
      tick();
    end

    // Back to the buffered line under halt, then fence.i and release
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100; #1;
    tick(); redirect_valid = 1'b0; #1;
    chk("halt_hit_valid", 64'(out_valid), 64'd0);
    inval = 1'b1;
    tick(); inval = 1'b0; halt = 1'b0; #1;
    chk("inval_valid", 64'(out_valid), 64'd0);
    chk("inval_req",   64'(mem_req),   64'd0);
    tick(); #1;
    chk("refetch_req",  64'(mem_req), 64'd1);
    chk("refetch_addr", mem_addr,     64'h8000_0100);
    mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h5555_5555_6666_6666; #1;
    tick(); mem_rvalid = 1'b0; #1;
    chk("refill_valid", 64'(out_valid), 64'd1);
    chk("refill_inst",  64'(out_inst),  64'h6666_6666);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
